// File: rtl/l2_port_arbiter.sv
// Two-port arbiter sharing one L2 between the instruction and data L1 caches.
// Round-robin on contention, one transaction in flight, with a one-cycle DONE gap between grants.
module l2_port_arbiter #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              L2_read,
  output logic              L2_write,
  output logic [ADDR_W-1:0] L2_addr,
  output logic [LINE_W-1:0] L2_wdata,
  input  logic [LINE_W-1:0] L2_rdata,
  input  logic              L2_ready,
  output logic              busy,
  output logic [15:0]       i_cnt,
  output logic [15:0]       d_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_d;
  logic [CNT_W-1:0] r_i_cnt;
  logic [CNT_W-1:0] r_d_cnt;
  logic             w_i_req;
  logic             w_d_req;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;
  assign i_cnt   = r_i_cnt;
  assign d_cnt   = r_d_cnt;

  // State, round-robin pointer and saturating completion counters
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_state  <= S_IDLE;
      r_last_d <= 1'b1;
      r_i_cnt  <= '0;
      r_d_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (i_ready) begin
        r_last_d <= 1'b0;
        if (r_i_cnt != CNT_MAX) r_i_cnt <= r_i_cnt + CNT_W'(1);
      end
      if (d_ready) begin
        r_last_d <= 1'b1;
        if (r_d_cnt != CNT_MAX) r_d_cnt <= r_d_cnt + CNT_W'(1);
      end
    end
  end

  // Next state plus the L2 mux; the granted side sees L2 live, the other side sees zeros
  always_comb begin
    w_next   = r_state;
    L2_read  = 1'b0;
    L2_write = 1'b0;
    L2_addr  = '0;
    L2_wdata = '0;
    i_ready  = 1'b0;
    i_rdata  = '0;
    d_ready  = 1'b0;
    d_rdata  = '0;
    busy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_i_req && w_d_req) w_next = r_last_d ? S_GNT_I : S_GNT_D;
        else if (w_i_req)       w_next = S_GNT_I;
        else if (w_d_req)       w_next = S_GNT_D;
      end
      S_GNT_I: begin
        busy    = 1'b1;
        L2_read = i_read;
        L2_addr = i_addr;
        if (L2_ready) begin
          i_ready = 1'b1;
          i_rdata = L2_rdata;
          w_next  = S_DONE;
        end
      end
      S_GNT_D: begin
        busy     = 1'b1;
        // A simultaneous read and write is a write-back
        L2_write = d_write;
        L2_read  = d_read & ~d_write;
        L2_addr  = d_addr;
        L2_wdata = d_wdata;
        if (L2_ready) begin
          d_ready = 1'b1;
          d_rdata = L2_rdata;
          w_next  = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: a vector table, hand-written corner sequences,
// and random traffic checked against a transaction-level model.
module tb_l2_port_arbiter;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned LINE_W = 128;

  logic              clk;
  logic              proc_reset;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_ready;
  logic              L2_read;
  logic              L2_write;
  logic [ADDR_W-1:0] L2_addr;
  logic [LINE_W-1:0] L2_wdata;
  logic [LINE_W-1:0] L2_rdata;
  logic              L2_ready;
  logic              busy;
  logic [15:0]       i_cnt;
  logic [15:0]       d_cnt;

  int checks;
  int fails;

  l2_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .L2_read(L2_read), .L2_write(L2_write), .L2_addr(L2_addr), .L2_wdata(L2_wdata),
    .L2_rdata(L2_rdata), .L2_ready(L2_ready),
    .busy(busy), .i_cnt(i_cnt), .d_cnt(d_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ir, dr, dw, rdy;
    logic        e_irdy, e_drdy, e_l2r, e_l2w;
    logic [1:0]  e_g;        // 0 none, 1 instruction, 2 data
    logic [15:0] e_ic, e_dc;
  } vec_t;

  function automatic vec_t mk(input logic ir, dr, dw, rdy, e_irdy, e_drdy, e_l2r, e_l2w,
                              input logic [1:0] e_g, input logic [15:0] e_ic, e_dc);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.rdy = rdy;
    v.e_irdy = e_irdy; v.e_drdy = e_drdy; v.e_l2r = e_l2r; v.e_l2w = e_l2w;
    v.e_g = e_g; v.e_ic = e_ic; v.e_dc = e_dc;
    return v;
  endfunction

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic ir, dr, dw, rdy);
    i_read = ir; d_read = dr; d_write = dw; L2_ready = rdy;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    set_in(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    proc_reset = 1'b0;
  endtask

  // Transaction-level reference model state
  int       m_st;     // 0 idle, 1 serving I, 2 serving D, 3 done gap
  logic     m_last_d;
  int       m_ic, m_dc;

  task automatic model_reset();
    m_st = 0; m_last_d = 1'b1; m_ic = 0; m_dc = 0;
  endtask

  task automatic random_cycle();
    logic              e_l2r, e_l2w, e_irdy, e_drdy, e_busy;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wd, e_ird, e_drd;
    int                nxt;
    @(negedge clk);
    i_read   = ($urandom % 3) != 0;
    d_read   = ($urandom % 2) != 0;
    d_write  = ($urandom % 3) == 0;
    L2_ready = ($urandom % 3) == 0;
    i_addr   = ADDR_W'($urandom);
    d_addr   = ADDR_W'($urandom);
    d_wdata  = {$urandom, $urandom, $urandom, $urandom};
    L2_rdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    e_l2r = 0; e_l2w = 0; e_irdy = 0; e_drdy = 0; e_busy = 0;
    e_addr = '0; e_wd = '0; e_ird = '0; e_drd = '0;
    nxt = m_st;
    if (m_st == 0) begin
      if (i_read && (d_read || d_write)) nxt = m_last_d ? 1 : 2;
      else if (i_read)                   nxt = 1;
      else if (d_read || d_write)        nxt = 2;
    end else if (m_st == 1) begin
      e_busy = 1; e_l2r = i_read; e_addr = i_addr;
      if (L2_ready) begin e_irdy = 1; e_ird = L2_rdata; nxt = 3; end
    end else if (m_st == 2) begin
      e_busy = 1; e_l2w = d_write; e_l2r = d_read && !d_write;
      e_addr = d_addr; e_wd = d_wdata;
      if (L2_ready) begin e_drdy = 1; e_drd = L2_rdata; nxt = 3; end
    end else begin
      nxt = 0;
    end
    check("rnd_strobes", LINE_W'({L2_read, L2_write, busy}), LINE_W'({e_l2r, e_l2w, e_busy}));
    check("rnd_addr", LINE_W'(L2_addr), LINE_W'(e_addr));
    check("rnd_wdata", L2_wdata, e_wd);
    check("rnd_i_side", LINE_W'({i_ready, i_rdata[63:0]}), LINE_W'({e_irdy, e_ird[63:0]}));
    check("rnd_d_side", LINE_W'({d_ready, d_rdata[63:0]}), LINE_W'({e_drdy, e_drd[63:0]}));
    check("rnd_cnts", LINE_W'({i_cnt, d_cnt}), LINE_W'({16'(m_ic), 16'(m_dc)}));
    @(posedge clk);
    if (e_irdy) begin m_last_d = 1'b0; if (m_ic < 65535) m_ic++; end
    if (e_drdy) begin m_last_d = 1'b1; if (m_dc < 65535) m_dc++; end
    m_st = nxt;
  endtask

  vec_t tbl[19];
  localparam logic [ADDR_W-1:0] IA = 30'h0123_4567;
  localparam logic [ADDR_W-1:0] DA = 30'h2ABC_DEF0;
  localparam logic [LINE_W-1:0] WD = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [LINE_W-1:0] RD = 128'h0F0F_1234_5678_9ABC_DEF0_1357_9BDF_2468;
  localparam logic [LINE_W-1:0] A5 = {16{8'hA5}};

  initial begin
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wd;
    logic [15:0]       e_sat;
    checks = 0; fails = 0;
    proc_reset = 1'b1;
    set_in(0, 0, 0, 0);
    i_addr = IA; d_addr = DA; d_wdata = WD; L2_rdata = RD;

    //          ir dr dw rdy  irdy drdy l2r l2w  g  ic dc
    tbl[0]  = mk(1, 0, 1, 0,   0, 0, 0, 0,  0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 0,   0, 0, 1, 0,  1, 0, 0);
    tbl[2]  = mk(1, 0, 1, 1,   1, 0, 1, 0,  1, 0, 0);
    tbl[3]  = mk(1, 0, 1, 1,   0, 0, 0, 0,  0, 1, 0);
    tbl[4]  = mk(1, 0, 1, 0,   0, 0, 0, 0,  0, 1, 0);
    tbl[5]  = mk(1, 0, 1, 1,   0, 1, 0, 1,  2, 1, 0);
    tbl[6]  = mk(1, 0, 1, 0,   0, 0, 0, 0,  0, 1, 1);
    tbl[7]  = mk(1, 0, 1, 0,   0, 0, 0, 0,  0, 1, 1);
    tbl[8]  = mk(1, 0, 1, 1,   1, 0, 1, 0,  1, 1, 1);
    tbl[9]  = mk(1, 0, 1, 0,   0, 0, 0, 0,  0, 2, 1);
    tbl[10] = mk(1, 0, 1, 0,   0, 0, 0, 0,  0, 2, 1);
    tbl[11] = mk(1, 0, 1, 1,   0, 1, 0, 1,  2, 2, 1);
    tbl[12] = mk(0, 0, 0, 1,   0, 0, 0, 0,  0, 2, 2);
    tbl[13] = mk(0, 0, 0, 1,   0, 0, 0, 0,  0, 2, 2);
    tbl[14] = mk(0, 1, 1, 0,   0, 0, 0, 0,  0, 2, 2);
    tbl[15] = mk(0, 1, 1, 0,   0, 0, 0, 1,  2, 2, 2);
    tbl[16] = mk(0, 0, 0, 0,   0, 0, 0, 0,  2, 2, 2);
    tbl[17] = mk(0, 0, 0, 1,   0, 1, 0, 0,  2, 2, 2);
    tbl[18] = mk(0, 0, 0, 0,   0, 0, 0, 0,  0, 2, 3);

    #1;
    check("reset_outputs", LINE_W'({busy, i_ready, d_ready, L2_read, L2_write}), '0);
    check("reset_cnts", LINE_W'({i_cnt, d_cnt}), '0);
    repeat (2) @(negedge clk);
    proc_reset = 1'b0;

    // Alternating grants, DONE gap, stray ready and no-abort behaviour
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      set_in(tbl[k].ir, tbl[k].dr, tbl[k].dw, tbl[k].rdy);
      #1;
      e_addr = (tbl[k].e_g == 2'd1) ? IA : (tbl[k].e_g == 2'd2) ? DA : '0;
      e_wd   = (tbl[k].e_g == 2'd2) ? WD : '0;
      check($sformatf("tbl%0d_strobes", k), LINE_W'({L2_read, L2_write, busy}),
            LINE_W'({tbl[k].e_l2r, tbl[k].e_l2w, tbl[k].e_g != 2'd0}));
      check($sformatf("tbl%0d_readies", k), LINE_W'({i_ready, d_ready}),
            LINE_W'({tbl[k].e_irdy, tbl[k].e_drdy}));
      check($sformatf("tbl%0d_addr", k), LINE_W'(L2_addr), LINE_W'(e_addr));
      check($sformatf("tbl%0d_wdata", k), L2_wdata, e_wd);
      check($sformatf("tbl%0d_i_rdata", k), i_rdata, tbl[k].e_irdy ? RD : '0);
      check($sformatf("tbl%0d_d_rdata", k), d_rdata, tbl[k].e_drdy ? RD : '0);
      check($sformatf("tbl%0d_cnts", k), LINE_W'({i_cnt, d_cnt}), LINE_W'({tbl[k].e_ic, tbl[k].e_dc}));
    end

    // Single instruction read, L2 answers on the third granted cycle
    do_reset();
    L2_rdata = A5;
    @(negedge clk); set_in(1, 0, 0, 0); #1;
    check("ird_idle_strobe", LINE_W'(L2_read), '0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); L2_ready = (c == 3); #1;
      check($sformatf("ird_c%0d_read", c), LINE_W'({L2_read, L2_write}), LINE_W'(2'b10));
      check($sformatf("ird_c%0d_addr", c), LINE_W'(L2_addr), LINE_W'(IA));
      check($sformatf("ird_c%0d_ready", c), LINE_W'({i_ready, d_ready}), LINE_W'({c == 3, 1'b0}));
    end
    check("ird_rdata", i_rdata, A5);
    @(negedge clk); set_in(0, 0, 0, 0); #1;
    check("ird_done_quiet", LINE_W'({busy, i_ready, d_ready, L2_read}), '0);
    check("ird_icnt", LINE_W'(i_cnt), LINE_W'(16'd1));

    // Async reset in the middle of a data grant, then a stray L2_ready
    do_reset();
    @(negedge clk); set_in(0, 1, 0, 0);
    @(negedge clk); #1;
    check("arst_pre_busy", LINE_W'({busy, L2_read}), LINE_W'(2'b11));
    #2; L2_ready = 1'b1; d_read = 1'b0; proc_reset = 1'b1; #1;
    check("arst_outputs", LINE_W'({busy, d_ready, i_ready, L2_read, L2_write}), '0);
    check("arst_rdata", d_rdata, '0);
    @(negedge clk); proc_reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check($sformatf("arst_stray%0d", c), LINE_W'({busy, d_ready, i_ready}), '0);
    end
    check("arst_dcnt", LINE_W'({i_cnt, d_cnt}), '0);

    // Random traffic against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) random_cycle();

    // Saturation: preload the data counter near the top, then run more transactions
    do_reset();
    @(negedge clk);
    force dut.r_d_cnt = 16'hFFFC;
    #1;
    release dut.r_d_cnt;
    d_write = 1'b1; d_addr = DA; d_wdata = WD; L2_ready = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      repeat (3) @(negedge clk);
      #1;
      e_sat = (t >= 3) ? 16'hFFFF : 16'(32'hFFFC + t);
      check($sformatf("sat_t%0d", t), LINE_W'(d_cnt), LINE_W'(e_sat));
    end
    set_in(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
